// File: rtl/life_grid_engine.sv
// life_grid_engine: Conway Game of Life engine on a 2^BIT_W x 2^BIT_H board.
// The display plane and the work plane are double-buffered. rd_alive looks up
// the last completed generation combinationally. A new generation is computed
// one cell per clock after step_req.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   step_req, clear_req  start a generation / clear board (clear aborts compute)
//   wr_en, wr_x, wr_y, wr_data  seed write into the display plane (IDLE only)
//   rd_x, rd_y, rd_alive combinational display-plane lookup
//   busy, done           compute in progress / one-cycle "new generation visible"
//   gen_count, pop_count completed generations, alive cells in display plane
// Optional: define LIFE_TORUS_EN for a wrap-around (torus) board; otherwise
// cells outside the board count as dead.
module life_grid_engine #(
    parameter int unsigned BIT_W = 4,
    parameter int unsigned BIT_H = 4,
    parameter int unsigned GEN_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   step_req,
    input  logic                   clear_req,
    input  logic                   wr_en,
    input  logic [BIT_W-1:0]       wr_x,
    input  logic [BIT_H-1:0]       wr_y,
    input  logic                   wr_data,
    input  logic [BIT_W-1:0]       rd_x,
    input  logic [BIT_H-1:0]       rd_y,
    output logic                   rd_alive,
    output logic                   busy,
    output logic                   done,
    output logic [GEN_W-1:0]       gen_count,
    output logic [BIT_W+BIT_H:0]   pop_count
);

    localparam int unsigned SIZE  = (2**BIT_W) * (2**BIT_H);
    localparam int unsigned IDX_W = BIT_W + BIT_H;
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_COMPUTE, ST_SWAP} state_t;

    state_t            state, state_next;
    logic              busy_next, done_next;
    logic [SIZE-1:0]   plane0, plane1;
    logic [SIZE-1:0]   disp;
    logic              sel;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  acc;

    logic [BIT_W-1:0]  cx, xl, xr;
    logic [BIT_H-1:0]  cy, yu, yd;
    logic              ok_l, ok_r, ok_t, ok_b;
    logic [3:0]        nb_sum;
    logic              new_cell;

    // sel chooses which physical plane is currently displayed
    assign disp     = sel ? plane1 : plane0;
    assign rd_alive = disp[{rd_y, rd_x}];

    // Neighbour coordinates of the cell being computed; wrap in BIT_W/BIT_H bits
    assign cx = idx[BIT_W-1:0];
    assign cy = idx[IDX_W-1:BIT_W];
    assign xl = cx - BIT_W'(1);
    assign xr = cx + BIT_W'(1);
    assign yu = cy - BIT_H'(1);
    assign yd = cy + BIT_H'(1);

`ifdef LIFE_TORUS_EN
    // Wrapped coordinates are real neighbours on a torus
    assign ok_l = 1'b1;
    assign ok_r = 1'b1;
    assign ok_t = 1'b1;
    assign ok_b = 1'b1;
`else
    // Hard edges: mask neighbours whose coordinate wrapped off the board
    assign ok_l = (cx != '0);
    assign ok_r = (cx != '1);
    assign ok_t = (cy != '0);
    assign ok_b = (cy != '1);
`endif

    // Neighbour count and life rule for cell idx
    always_comb begin
        nb_sum = 4'(disp[{yu, xl}] & ok_t & ok_l)
               + 4'(disp[{yu, cx}] & ok_t)
               + 4'(disp[{yu, xr}] & ok_t & ok_r)
               + 4'(disp[{cy, xl}] & ok_l)
               + 4'(disp[{cy, xr}] & ok_r)
               + 4'(disp[{yd, xl}] & ok_b & ok_l)
               + 4'(disp[{yd, cx}] & ok_b)
               + 4'(disp[{yd, xr}] & ok_b & ok_r);
        new_cell = (nb_sum == 4'd3) | (disp[idx] & (nb_sum == 4'd2));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state and registered-output next values
    always_comb begin
        state_next = state;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        if (clear_req) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!wr_en && step_req) begin
                        state_next = ST_COMPUTE;
                        busy_next  = 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    busy_next = 1'b1;
                    if (idx == IDX_W'(SIZE - 1)) state_next = ST_SWAP;
                end
                ST_SWAP: begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Planes, scan index, accumulator and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plane0    <= '0;
            plane1    <= '0;
            sel       <= 1'b0;
            idx       <= '0;
            acc       <= '0;
            gen_count <= '0;
            pop_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            if (clear_req) begin
                plane0    <= '0;
                plane1    <= '0;
                idx       <= '0;
                acc       <= '0;
                gen_count <= '0;
                pop_count <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (wr_en) begin
                            if (sel) plane1[{wr_y, wr_x}] <= wr_data;
                            else     plane0[{wr_y, wr_x}] <= wr_data;
                        end else if (step_req) begin
                            idx <= '0;
                            acc <= '0;
                        end
                    end
                    ST_COMPUTE: begin
                        // Results go to the non-displayed plane
                        if (sel) plane0[idx] <= new_cell;
                        else     plane1[idx] <= new_cell;
                        acc <= acc + CNT_W'(new_cell);
                        idx <= idx + IDX_W'(1);
                    end
                    ST_SWAP: begin
                        sel       <= ~sel;
                        pop_count <= acc;
                        gen_count <= gen_count + GEN_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_grid_engine.sv
// Testbench for life_grid_engine (16x16 board, default parameters).
module tb_life_grid_engine;

    localparam int BW = 16;
    localparam int BH = 16;
    localparam int T_LAT = 257;  // edges from step_req sample edge to done visible

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step_req = 1'b0;
    logic        clear_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_x = '0;
    logic [3:0]  wr_y = '0;
    logic        wr_data = 1'b0;
    logic [3:0]  rd_x = '0;
    logic [3:0]  rd_y = '0;
    logic        rd_alive;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;
    logic [8:0]  pop_count;

    int vectors = 0;
    int errors  = 0;

    int model [0:BH-1][0:BW-1];
    int seedb [0:BH-1][0:BW-1];
    bit dut_b [0:BH-1][0:BW-1];
    int m_gen = 0;
    int m_pop = 0;

    life_grid_engine dut (
        .clk(clk), .rst_n(rst_n), .step_req(step_req), .clear_req(clear_req),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .rd_x(rd_x), .rd_y(rd_y), .rd_alive(rd_alive), .busy(busy), .done(done),
        .gen_count(gen_count), .pop_count(pop_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int model_cell(int x, int y);
`ifdef LIFE_TORUS_EN
        x = (x + BW) % BW;
        y = (y + BH) % BH;
`else
        if (x < 0 || x >= BW || y < 0 || y >= BH) return 0;
`endif
        return model[y][x];
    endfunction

    task automatic model_step();
        int nxt [0:BH-1][0:BW-1];
        int n;
        m_pop = 0;
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0) n += model_cell(x + dx, y + dy);
                nxt[y][x] = (n == 3 || (model[y][x] == 1 && n == 2)) ? 1 : 0;
                m_pop += nxt[y][x];
            end
        model = nxt;
        m_gen = (m_gen + 1) % 65536;
    endtask

    task automatic model_clear();
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++) model[y][x] = 0;
        m_gen = 0;
        m_pop = 0;
    endtask

    function automatic int count_diffs();
        int d = 0;
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                if (int'(dut_b[y][x]) != model[y][x]) d++;
        return d;
    endfunction

    // ---------------- stimulus helpers (time aligned to posedge+1) ----------------
    task automatic read_board();
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++) begin
                rd_x = 4'(x);
                rd_y = 4'(y);
                #1;
                dut_b[y][x] = rd_alive;
            end
        @(posedge clk); #1;
    endtask

    task automatic seed_cell(int x, int y, int v);
        wr_en = 1'b1; wr_x = 4'(x); wr_y = 4'(y); wr_data = 1'(v);
        @(posedge clk); #1;
        wr_en = 1'b0;
        model[y][x] = v;
    endtask

    task automatic do_clear();
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        model_clear();
    endtask

    task automatic do_step(output int lat, output int busy_cyc);
        lat = -1;
        busy_cyc = 0;
        step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cyc++;
            @(posedge clk); #1;
        end
        model_step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
        end
        vectors++;
        if (gen_count !== 16'd0 || pop_count !== 9'd0) begin
            errors++; $display("FAIL reset_counts gen=%0d pop=%0d want 0 0", gen_count, pop_count);
        end
        model_clear();
        read_board();
        vectors++;
        if (count_diffs() != 0) begin
            errors++; $display("FAIL reset_board %0d live cells want 0", count_diffs());
        end
    endtask

    task automatic test_blinker();
        int lat, bc;
        do_clear();
        seed_cell(4, 5, 1); seed_cell(5, 5, 1); seed_cell(6, 5, 1);
        do_step(lat, bc);
        vectors++;
        if (lat != T_LAT || bc != 257) begin
            errors++; $display("FAIL blinker_latency lat=%0d busy=%0d want %0d 257", lat, bc, T_LAT);
        end
        read_board();
        vectors++;
        if (!(dut_b[4][5] && dut_b[5][5] && dut_b[6][5]) || dut_b[5][4] || dut_b[5][6]) begin
            errors++; $display("FAIL blinker_vertical got %b%b%b/%b%b want 111/00",
                dut_b[4][5], dut_b[5][5], dut_b[6][5], dut_b[5][4], dut_b[5][6]);
        end
        vectors++;
        if (count_diffs() != 0) begin
            errors++; $display("FAIL blinker_board1 %0d cells differ", count_diffs());
        end
        vectors++;
        if (pop_count !== 9'd3 || gen_count !== 16'd1) begin
            errors++; $display("FAIL blinker_counts1 pop=%0d gen=%0d want 3 1", pop_count, gen_count);
        end
        do_step(lat, bc);
        read_board();
        vectors++;
        if (count_diffs() != 0 || !dut_b[5][4] || !dut_b[5][6] || dut_b[4][5]) begin
            errors++; $display("FAIL blinker_board2 %0d cells differ", count_diffs());
        end
        vectors++;
        if (pop_count !== 9'd3 || gen_count !== 16'd2) begin
            errors++; $display("FAIL blinker_counts2 pop=%0d gen=%0d want 3 2", pop_count, gen_count);
        end
    endtask

    task automatic test_block();
        int lat, bc;
        do_clear();
        seed_cell(0, 0, 1); seed_cell(1, 0, 1); seed_cell(0, 1, 1);
        for (int g = 1; g <= 3; g++) begin
            do_step(lat, bc);
            read_board();
            vectors++;
            if (!dut_b[1][1] || count_diffs() != 0) begin
                errors++; $display("FAIL block_gen%0d cell11=%b diffs=%0d want 1 0", g, dut_b[1][1], count_diffs());
            end
            vectors++;
            if (pop_count !== 9'd4 || gen_count !== 16'(g)) begin
                errors++; $display("FAIL block_counts%0d pop=%0d gen=%0d want 4 %0d", g, pop_count, gen_count, g);
            end
        end
    endtask

    task automatic test_random();
        int lat, bc;
        for (int r = 0; r < 4; r++) begin
            do_clear();
            for (int y = 0; y < BH; y++)
                for (int x = 0; x < BW; x++)
                    if ($urandom_range(0, 2) == 0) seed_cell(x, y, 1);
            for (int g = 0; g < 3; g++) begin
                do_step(lat, bc);
                read_board();
                vectors++;
                if (count_diffs() != 0 || lat != T_LAT) begin
                    errors++; $display("FAIL random_r%0d_g%0d diffs=%0d lat=%0d want 0 %0d", r, g, count_diffs(), lat, T_LAT);
                end
                vectors++;
                if (pop_count !== 9'(m_pop) || gen_count !== 16'(m_gen)) begin
                    errors++; $display("FAIL random_counts_r%0d_g%0d pop=%0d gen=%0d want %0d %0d",
                        r, g, pop_count, gen_count, m_pop, m_gen);
                end
            end
        end
    endtask

    task automatic test_glider();
        int lat, bc;
        int bad = 0;
        do_clear();
        seed_cell(13, 12, 1); seed_cell(14, 13, 1);
        seed_cell(12, 14, 1); seed_cell(13, 14, 1); seed_cell(14, 14, 1);
        seedb = model;
        for (int g = 1; g <= 4 * BW; g++) begin
            do_step(lat, bc);
            vectors++;
`ifdef LIFE_TORUS_EN
            if (pop_count !== 9'(m_pop) || pop_count !== 9'd5 || lat != T_LAT) begin
`else
            if (pop_count !== 9'(m_pop) || lat != T_LAT) begin
`endif
                errors++; bad++;
                if (bad < 4) $display("FAIL glider_pop_g%0d pop=%0d lat=%0d want %0d %0d", g, pop_count, lat, m_pop, T_LAT);
            end
        end
        read_board();
        vectors++;
        if (count_diffs() != 0 || gen_count !== 16'd64) begin
            errors++; $display("FAIL glider_final diffs=%0d gen=%0d want 0 64", count_diffs(), gen_count);
        end
`ifdef LIFE_TORUS_EN
        bad = 0;
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                if (int'(dut_b[y][x]) != seedb[y][x]) bad++;
        vectors++;
        if (bad != 0) begin
            errors++; $display("FAIL glider_torus_return %0d cells differ from seed want 0", bad);
        end
`endif
    endtask

    task automatic test_protocol();
        int bc = 0;
        int dn = 0;
        int dn_at = -1;
        do_clear();
        seed_cell(4, 5, 1); seed_cell(5, 5, 1); seed_cell(6, 5, 1);
        step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (busy) bc++;
            if (done) begin
                dn++;
                dn_at = i;
            end
            step_req = (i == 10 || i == 40);
            wr_en = (i == 20);
            wr_x = 4'd0; wr_y = 4'd0; wr_data = 1'b1;
            @(posedge clk); #1;
        end
        step_req = 1'b0;
        wr_en = 1'b0;
        model_step();
        vectors++;
        if (bc != 257 || dn != 1 || dn_at != T_LAT) begin
            errors++; $display("FAIL protocol_timing busy=%0d dones=%0d at=%0d want 257 1 %0d", bc, dn, dn_at, T_LAT);
        end
        read_board();
        vectors++;
        if (count_diffs() != 0 || gen_count !== 16'd1 || pop_count !== 9'd3) begin
            errors++; $display("FAIL protocol_result diffs=%0d gen=%0d pop=%0d want 0 1 3", count_diffs(), gen_count, pop_count);
        end
    endtask

    task automatic test_abort();
        int dn = 0;
        step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
        for (int i = 0; i < 99; i++) begin
            @(posedge clk); #1;
        end
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        model_clear();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_flags busy=%b done=%b want 0 0", busy, done);
        end
        for (int i = 0; i < 300; i++) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        vectors++;
        if (dn != 0 || gen_count !== 16'd0 || pop_count !== 9'd0) begin
            errors++; $display("FAIL abort_counts dones=%0d gen=%0d pop=%0d want 0 0 0", dn, gen_count, pop_count);
        end
        read_board();
        vectors++;
        if (count_diffs() != 0) begin
            errors++; $display("FAIL abort_board %0d live cells want 0", count_diffs());
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        seed_cell(4, 5, 1); seed_cell(5, 5, 1); seed_cell(6, 5, 1);
        do_step(lat, bc);
        step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'd0 || pop_count !== 9'd0) begin
            errors++; $display("FAIL midreset_outputs busy=%b done=%b gen=%0d pop=%0d want 0 0 0 0",
                busy, done, gen_count, pop_count);
        end
        read_board();
        vectors++;
        if (count_diffs() != 0) begin
            errors++; $display("FAIL midreset_board %0d live cells want 0", count_diffs());
        end
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'd0) begin
            errors++; $display("FAIL midreset_after busy=%b done=%b gen=%0d want 0 0 0", busy, done, gen_count);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_blinker();
        test_block();
        test_random();
        test_glider();
        test_protocol();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
